timer0_unit: RTL and testbench
==============================

Name: timer0_unit

Overview:
- Timer/Counter0 peripheral. Sits directly upstream of the interrupt controller and drives its TIFR and TIMSK inputs.
- Holds 8-bit TCNT0, the compare registers OCR0A/OCR0B, the control registers TCCR0A/TCCR0B, TIMSK and TIFR.
- Runs a prescaled counter with Normal and CTC modes and sets the overflow and compare flags.
- Clears a flag when the CPU writes 1 to it, or when the CPU acknowledges the matching interrupt vector.

Parameters:
- DATA_WIDTH, 8, register and bus width.
- I_ADDR_WIDTH, 10, width of the interrupt vector on ack_vector.
- IO_ADDR_WIDTH, 6, I/O-space address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- io_addr  in  IO_ADDR_WIDTH  I/O register address. TCCR0A=0x2A, TCCR0B=0x33, TCNT0=0x32, OCR0A=0x29, OCR0B=0x28, TIMSK=0x39, TIFR=0x38.
- io_wdata  in  DATA_WIDTH  write data.
- io_we  in  1  write strobe, sampled at posedge clk.
- io_rdata  out  DATA_WIDTH  combinational read of the addressed register; 0 for unmapped addresses.
- irq_ack  in  1  CPU is entering the ISR given by ack_vector.
- ack_vector  in  I_ADDR_WIDTH  vector being acknowledged.
- tifr  out  DATA_WIDTH  TIFR register, feeds the interrupt controller.
- timsk  out  DATA_WIDTH  TIMSK register, feeds the interrupt controller.

Behaviour:
- Reset (async): all registers, the prescaler counter, tifr and timsk go to 0. io_rdata is therefore 0.
- Bit positions: TOV0=1, OCF0B=3, OCF0A=4 in TIFR; TOIE0=1, OCIE0B=3, OCIE0A=4 in TIMSK.
- Unused TIFR/TIMSK bits always read 0, and writes to them are ignored.
- Mode select: WGM0 = {TCCR0B[3], TCCR0A[1:0]}.
  - 000 = Normal.
  - 010 = CTC.
  - Any other value behaves as Normal.
- Prescaler: CS0 = TCCR0B[2:0]. A 10-bit free-running prescaler counter produces a one-cycle tick.
  - 0 = stopped (no ticks, prescaler held at 0).
  - 1 = tick every cycle.
  - 2 = /8, 3 = /64, 4 = /256, 5 = /1024.
  - 6 and 7 = stopped (no external clock source).
  - On a tick cycle with TCNT0 = T:
    - Normal mode: next TCNT0 = T+1, wrapping 0xFF to 0x00.
    - CTC mode: next TCNT0 = 0 if T == OCR0A, else T+1 (wrapping).
    - TOV0 is set if T == 0xFF, in either mode.
    - OCF0A is set if T == OCR0A.
    - OCF0B is set if T == OCR0B.
    - All flag sets and the count update take effect on the same edge.
- Compare and overflow detection happens only on tick cycles. A held count never re-sets a flag.
- CPU write to TCNT0: the written value loads and overrides the increment. No tick events (count or flags) occur in that cycle.
- CPU write to TIFR: each bit written as 1 clears that flag; bits written as 0 leave the flag unchanged.
- Hardware clear via irq_ack, using the vector codes defined in defines.vh:
  - ack of TIM0_OVF_ISR clears TOV0.
  - ack of TIM0_COMPA_ISR clears OCF0A.
  - ack of TIM0_COMPB_ISR clears OCF0B.
  - ack of any other vector has no effect.
- Priority per flag bit: hardware set > CPU write-1 clear = ack clear > hold. A set in the same cycle as a clear leaves the flag at 1.
- Writes to the other registers (TCCR0A, TCCR0B, OCR0A, OCR0B, TIMSK) update on the next edge. The new value is used from the following cycle.
- Writing TCCR0B with a different CS0 value resets the prescaler counter to 0, so the first tick of the new rate is a full period away.
- Latency: tifr/timsk outputs are registered and change one edge after the causing event. There is no extra pipeline stage.

Test Plan:
- Reset asserted mid-count (TCNT0=0x57, TOV0=1) -> TCNT0, tifr, timsk and io_rdata all read 0 immediately, before the next clk edge.
- Normal mode, CS0=1, TCNT0 written 0xFD -> TCNT0 goes 0xFE, 0xFF, 0x00; tifr[1] rises on the edge where TCNT0 becomes 0x00.
- CTC mode, OCR0A=0x04, CS0=1, starting from 0 -> TCNT0 sequence 0,1,2,3,4,0,1…; OCF0A sets every 5 cycles; TOV0 never sets.
- CS0=2, start from 0 -> TCNT0 increments once per 8 clk cycles; CS0 changed to 0 -> TCNT0 freezes and no flags change.
- OCR0B=0x10 and TCNT0 reaches 0x10 -> tifr[3]=1. TIFR write 0x08 -> cleared. irq_ack with TIM0_COMPB_ISR in the same cycle as a new match -> tifr[3] stays 1.
- TOV0 and OCF0A both set, irq_ack with TIM0_OVF_ISR -> only tifr[1] clears; tifr[4] stays 1. ack of an unrelated vector -> no change.

Source files
------------

// File: rtl/timer0_unit.sv
// Timer/Counter0: 8-bit counter with a shared prescaler, Normal and CTC modes,
// overflow/compare flags (TIFR) and interrupt masks (TIMSK) that feed the
// interrupt controller. The flags clear on a CPU write-1 or an ISR acknowledge.
module timer0_unit #(
  parameter int DATA_WIDTH    = 8,
  parameter int I_ADDR_WIDTH  = 10,
  parameter int IO_ADDR_WIDTH = 6,
  // Vector codes for the three Timer0 interrupts; must match defines.vh
  parameter logic [I_ADDR_WIDTH-1:0] TIM0_COMPA_ISR = 10'h01C,
  parameter logic [I_ADDR_WIDTH-1:0] TIM0_COMPB_ISR = 10'h01E,
  parameter logic [I_ADDR_WIDTH-1:0] TIM0_OVF_ISR   = 10'h020
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IO_ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0]    io_wdata,
  input  logic                     io_we,
  output logic [DATA_WIDTH-1:0]    io_rdata,
  input  logic                     irq_ack,
  input  logic [I_ADDR_WIDTH-1:0]  ack_vector,
  output logic [DATA_WIDTH-1:0]    tifr,
  output logic [DATA_WIDTH-1:0]    timsk
);

  localparam logic [IO_ADDR_WIDTH-1:0] ADDR_OCR0B  = IO_ADDR_WIDTH'('h28);
  localparam logic [IO_ADDR_WIDTH-1:0] ADDR_OCR0A  = IO_ADDR_WIDTH'('h29);
  localparam logic [IO_ADDR_WIDTH-1:0] ADDR_TCCR0A = IO_ADDR_WIDTH'('h2A);
  localparam logic [IO_ADDR_WIDTH-1:0] ADDR_TCNT0  = IO_ADDR_WIDTH'('h32);
  localparam logic [IO_ADDR_WIDTH-1:0] ADDR_TCCR0B = IO_ADDR_WIDTH'('h33);
  localparam logic [IO_ADDR_WIDTH-1:0] ADDR_TIFR   = IO_ADDR_WIDTH'('h38);
  localparam logic [IO_ADDR_WIDTH-1:0] ADDR_TIMSK  = IO_ADDR_WIDTH'('h39);

  localparam int BIT_TOV0  = 1;
  localparam int BIT_OCF0B = 3;
  localparam int BIT_OCF0A = 4;

  // Only bits 1, 3 and 4 exist in TIFR/TIMSK
  localparam logic [DATA_WIDTH-1:0] FLAG_MASK = DATA_WIDTH'('h1A);

  localparam logic [2:0] WGM_CTC = 3'b010;

  logic [DATA_WIDTH-1:0] tccr0a;
  logic [DATA_WIDTH-1:0] tccr0b;
  logic [DATA_WIDTH-1:0] tcnt0;
  logic [DATA_WIDTH-1:0] ocr0a;
  logic [DATA_WIDTH-1:0] ocr0b;
  logic [9:0]            presc;

  logic [2:0] wgm;
  logic [2:0] cs;
  logic       ctc_mode;
  logic       run;
  logic       tick;
  logic       evt;

  logic wr_tccr0a, wr_tccr0b, wr_tcnt0, wr_ocr0a, wr_ocr0b, wr_tifr, wr_timsk;

  logic [DATA_WIDTH-1:0] flag_set;
  logic [DATA_WIDTH-1:0] flag_clr;
  logic [DATA_WIDTH-1:0] tifr_next;

  assign wgm      = {tccr0b[3], tccr0a[1:0]};
  assign cs       = tccr0b[2:0];
  assign ctc_mode = (wgm == WGM_CTC);

  assign wr_tccr0a = io_we && (io_addr == ADDR_TCCR0A);
  assign wr_tccr0b = io_we && (io_addr == ADDR_TCCR0B);
  assign wr_tcnt0  = io_we && (io_addr == ADDR_TCNT0);
  assign wr_ocr0a  = io_we && (io_addr == ADDR_OCR0A);
  assign wr_ocr0b  = io_we && (io_addr == ADDR_OCR0B);
  assign wr_tifr   = io_we && (io_addr == ADDR_TIFR);
  assign wr_timsk  = io_we && (io_addr == ADDR_TIMSK);

  // Decode the clock select into a run enable and a one-cycle tick
  always_comb begin
    run  = 1'b0;
    tick = 1'b0;
    case (cs)
      3'd1: begin run = 1'b1; tick = 1'b1;                    end
      3'd2: begin run = 1'b1; tick = (presc[2:0] == 3'h7);    end
      3'd3: begin run = 1'b1; tick = (presc[5:0] == 6'h3F);   end
      3'd4: begin run = 1'b1; tick = (presc[7:0] == 8'hFF);   end
      3'd5: begin run = 1'b1; tick = (presc == 10'h3FF);      end
      default: begin run = 1'b0; tick = 1'b0;                 end
    endcase
  end

  // A CPU write to TCNT0 swallows the tick: no count or flag events that cycle
  assign evt = tick && !wr_tcnt0;

  // Flag set/clear vectors; set wins over either clear source
  always_comb begin
    flag_set = '0;
    flag_clr = '0;
    flag_set[BIT_TOV0]  = evt && (tcnt0 == '1);
    flag_set[BIT_OCF0A] = evt && (tcnt0 == ocr0a);
    flag_set[BIT_OCF0B] = evt && (tcnt0 == ocr0b);
    if (wr_tifr) begin
      flag_clr = io_wdata;
    end
    if (irq_ack) begin
      if (ack_vector == TIM0_OVF_ISR)   flag_clr[BIT_TOV0]  = 1'b1;
      if (ack_vector == TIM0_COMPA_ISR) flag_clr[BIT_OCF0A] = 1'b1;
      if (ack_vector == TIM0_COMPB_ISR) flag_clr[BIT_OCF0B] = 1'b1;
    end
    tifr_next = ((tifr & ~flag_clr) | flag_set) & FLAG_MASK;
  end

  // Prescaler: free-running while enabled, restarted whenever CS0 changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (wr_tccr0b && (io_wdata[2:0] != cs)) begin
      presc <= '0;
    end else if (!run) begin
      presc <= '0;
    end else begin
      presc <= presc + 10'd1;
    end
  end

  // Counter: CPU load has priority over the tick-driven update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt0 <= '0;
    end else if (wr_tcnt0) begin
      tcnt0 <= io_wdata;
    end else if (tick) begin
      if (ctc_mode && (tcnt0 == ocr0a)) begin
        tcnt0 <= '0;
      end else begin
        tcnt0 <= tcnt0 + 1'b1;
      end
    end
  end

  // Control, compare and mask registers written from the I/O bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tccr0a <= '0;
      tccr0b <= '0;
      ocr0a  <= '0;
      ocr0b  <= '0;
      timsk  <= '0;
    end else begin
      if (wr_tccr0a) tccr0a <= io_wdata;
      if (wr_tccr0b) tccr0b <= io_wdata;
      if (wr_ocr0a)  ocr0a  <= io_wdata;
      if (wr_ocr0b)  ocr0b  <= io_wdata;
      if (wr_timsk)  timsk  <= io_wdata & FLAG_MASK;
    end
  end

  // Interrupt flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tifr <= '0;
    end else begin
      tifr <= tifr_next;
    end
  end

  // Combinational read-back of the addressed register
  always_comb begin
    case (io_addr)
      ADDR_TCCR0A: io_rdata = tccr0a;
      ADDR_TCCR0B: io_rdata = tccr0b;
      ADDR_TCNT0:  io_rdata = tcnt0;
      ADDR_OCR0A:  io_rdata = ocr0a;
      ADDR_OCR0B:  io_rdata = ocr0b;
      ADDR_TIMSK:  io_rdata = timsk;
      ADDR_TIFR:   io_rdata = tifr;
      default:     io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer0_unit.sv
// Directed bench for timer0_unit: one task per feature, inline checks.
module tb_timer0_unit;

  localparam logic [5:0] A_OCR0B  = 6'h28;
  localparam logic [5:0] A_OCR0A  = 6'h29;
  localparam logic [5:0] A_TCCR0A = 6'h2A;
  localparam logic [5:0] A_TCNT0  = 6'h32;
  localparam logic [5:0] A_TCCR0B = 6'h33;
  localparam logic [5:0] A_TIFR   = 6'h38;
  localparam logic [5:0] A_TIMSK  = 6'h39;

  localparam logic [9:0] V_COMPA = 10'h01C;
  localparam logic [9:0] V_COMPB = 10'h01E;
  localparam logic [9:0] V_OVF   = 10'h020;
  localparam logic [9:0] V_OTHER = 10'h002;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] io_addr = '0;
  logic [7:0] io_wdata = '0;
  logic       io_we = 1'b0;
  logic [7:0] io_rdata;
  logic       irq_ack = 1'b0;
  logic [9:0] ack_vector = '0;
  logic [7:0] tifr;
  logic [7:0] timsk;

  int tests = 0;
  int fails = 0;

  timer0_unit dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_rdata(io_rdata), .irq_ack(irq_ack),
    .ack_vector(ack_vector), .tifr(tifr), .timsk(timsk)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_we = 1'b1;
    @(posedge clk); #1;
    io_we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    io_addr = a; #1; d = io_rdata;
  endtask

  task automatic ack(input logic [9:0] v);
    irq_ack = 1'b1; ack_vector = v;
    @(posedge clk); #1;
    irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; #3; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #3;
    rd(A_TCNT0, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_tcnt0: got %h want 00", d); end
    rd(A_TCCR0B, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_tccr0b: got %h want 00", d); end
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL reset_tifr: got %h want 00", tifr); end
    tests++; if (timsk !== 8'h00) begin fails++; $display("FAIL reset_timsk: got %h want 00", timsk); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_regs();
    logic [7:0] d;
    wr(A_OCR0A, 8'h5A);
    wr(A_OCR0B, 8'h10);
    wr(A_TIMSK, 8'hFF);
    wr(6'h00, 8'hFF);
    wr(A_TIFR, 8'hFF);
    rd(A_OCR0A, d);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL regs_ocr0a: got %h want 5a", d); end
    rd(A_OCR0B, d);
    tests++; if (d !== 8'h10) begin fails++; $display("FAIL regs_ocr0b: got %h want 10", d); end
    tests++; if (timsk !== 8'h1A) begin fails++; $display("FAIL regs_timsk_out: got %h want 1a", timsk); end
    rd(A_TIMSK, d);
    tests++; if (d !== 8'h1A) begin fails++; $display("FAIL regs_timsk_rd: got %h want 1a", d); end
    rd(6'h00, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL regs_unmapped: got %h want 00", d); end
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL regs_tifr: got %h want 00", tifr); end
    wr(A_TIMSK, 8'h00);
  endtask

  task automatic test_normal_ovf();
    logic [7:0] d;
    wr(A_TCNT0, 8'hFD);
    wr(A_TCCR0B, 8'h01);
    rd(A_TCNT0, d);
    tests++; if (d !== 8'hFD) begin fails++; $display("FAIL ovf_start: got %h want fd", d); end
    step(1); rd(A_TCNT0, d);
    tests++; if (d !== 8'hFE) begin fails++; $display("FAIL ovf_fe: got %h want fe", d); end
    step(1); rd(A_TCNT0, d);
    tests++; if (d !== 8'hFF) begin fails++; $display("FAIL ovf_ff: got %h want ff", d); end
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL ovf_tifr_early: got %h want 00", tifr); end
    step(1); rd(A_TCNT0, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL ovf_wrap: got %h want 00", d); end
    tests++; if (tifr !== 8'h02) begin fails++; $display("FAIL ovf_tov0: got %h want 02", tifr); end
    wr(A_TCCR0B, 8'h00);
    step(5); rd(A_TCNT0, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL ovf_frozen: got %h want 01", d); end
  endtask

  task automatic test_reset_midcount();
    logic [7:0] d;
    wr(A_TCNT0, 8'h57);
    wr(A_TIMSK, 8'h12);
    wr(A_TCCR0B, 8'h01);
    step(1); rd(A_TCNT0, d);
    tests++; if (d !== 8'h58) begin fails++; $display("FAIL mid_pre_tcnt: got %h want 58", d); end
    tests++; if (tifr !== 8'h02 || timsk !== 8'h12) begin
      fails++; $display("FAIL mid_pre_flags: got tifr %h timsk %h want 02 12", tifr, timsk); end
    #2 reset = 1'b1;
    rd(A_TCNT0, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL mid_rst_tcnt: got %h want 00", d); end
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL mid_rst_tifr: got %h want 00", tifr); end
    tests++; if (timsk !== 8'h00) begin fails++; $display("FAIL mid_rst_timsk: got %h want 00", timsk); end
    reset = 1'b0;
    step(3); rd(A_TCNT0, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL mid_post_stopped: got %h want 00", d); end
  endtask

  task automatic test_ctc();
    logic [7:0] d;
    logic [7:0] exp_f;
    do_reset();
    wr(A_OCR0A, 8'h04);
    wr(A_OCR0B, 8'h10);
    wr(A_TCCR0A, 8'h02);
    wr(A_TCCR0B, 8'h01);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1 && (k % 5) == 1) wr(A_TIFR, 8'h10);
      else step(1);
      rd(A_TCNT0, d);
      tests++; if (d !== 8'(k % 5)) begin
        fails++; $display("FAIL ctc_tcnt k=%0d: got %h want %h", k, d, 8'(k % 5)); end
      exp_f = ((k % 5) == 0) ? 8'h10 : 8'h00;
      tests++; if (tifr !== exp_f) begin
        fails++; $display("FAIL ctc_tifr k=%0d: got %h want %h", k, tifr, exp_f); end
    end
  endtask

  task automatic test_prescale();
    logic [7:0] d;
    do_reset();
    wr(A_OCR0A, 8'hF0);
    wr(A_OCR0B, 8'hF0);
    wr(A_TCCR0B, 8'h02);
    for (int k = 1; k <= 24; k++) begin
      step(1); rd(A_TCNT0, d);
      tests++; if (d !== 8'(k / 8)) begin
        fails++; $display("FAIL div8 k=%0d: got %h want %h", k, d, 8'(k / 8)); end
    end
    wr(A_TCCR0B, 8'h00);
    step(16); rd(A_TCNT0, d);
    tests++; if (d !== 8'h03) begin fails++; $display("FAIL stop_hold: got %h want 03", d); end
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL stop_tifr: got %h want 00", tifr); end
    wr(A_TCCR0B, 8'h02);
    step(4);
    wr(A_TCCR0B, 8'h03);
    wr(A_TCCR0B, 8'h02);
    step(7); rd(A_TCNT0, d);
    tests++; if (d !== 8'h03) begin fails++; $display("FAIL cs_change_wait: got %h want 03", d); end
    step(1); rd(A_TCNT0, d);
    tests++; if (d !== 8'h04) begin fails++; $display("FAIL cs_change_tick: got %h want 04", d); end
  endtask

  task automatic test_compb();
    logic [7:0] d;
    do_reset();
    wr(A_OCR0A, 8'hF0);
    wr(A_OCR0B, 8'h10);
    wr(A_TCNT0, 8'h0E);
    wr(A_TCCR0B, 8'h01);
    step(2); rd(A_TCNT0, d);
    tests++; if (d !== 8'h10 || tifr !== 8'h00) begin
      fails++; $display("FAIL compb_pre: got tcnt %h tifr %h want 10 00", d, tifr); end
    step(1);
    tests++; if (tifr !== 8'h08) begin fails++; $display("FAIL compb_set: got %h want 08", tifr); end
    wr(A_TIFR, 8'h08);
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL compb_w1c: got %h want 00", tifr); end
    wr(A_TCNT0, 8'h0F);
    rd(A_TCNT0, d);
    tests++; if (d !== 8'h0F) begin fails++; $display("FAIL compb_load: got %h want 0f", d); end
    step(1);
    ack(V_COMPB);
    tests++; if (tifr !== 8'h08) begin fails++; $display("FAIL compb_ack_vs_set: got %h want 08", tifr); end
    ack(V_COMPB);
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL compb_ack_clr: got %h want 00", tifr); end
    wr(A_TCNT0, 8'h0F);
    step(1);
    wr(A_TIFR, 8'h08);
    tests++; if (tifr !== 8'h08) begin fails++; $display("FAIL compb_w1c_vs_set: got %h want 08", tifr); end
  endtask

  task automatic test_ack();
    logic [7:0] d;
    do_reset();
    wr(A_OCR0A, 8'hFF);
    wr(A_OCR0B, 8'h10);
    wr(A_TCNT0, 8'hFE);
    wr(A_TCCR0B, 8'h01);
    step(2);
    tests++; if (tifr !== 8'h12) begin fails++; $display("FAIL ack_both_set: got %h want 12", tifr); end
    wr(A_TCCR0B, 8'h00);
    rd(A_TCNT0, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL ack_stopped: got %h want 01", d); end
    ack(V_OTHER);
    tests++; if (tifr !== 8'h12) begin fails++; $display("FAIL ack_other: got %h want 12", tifr); end
    wr(A_TIFR, 8'h00);
    tests++; if (tifr !== 8'h12) begin fails++; $display("FAIL ack_w0: got %h want 12", tifr); end
    ack(V_OVF);
    tests++; if (tifr !== 8'h10) begin fails++; $display("FAIL ack_ovf: got %h want 10", tifr); end
    wr(A_TIFR, 8'hE5);
    tests++; if (tifr !== 8'h10) begin fails++; $display("FAIL ack_unused_bits: got %h want 10", tifr); end
    ack(V_COMPA);
    tests++; if (tifr !== 8'h00) begin fails++; $display("FAIL ack_compa: got %h want 00", tifr); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_normal_ovf();
    test_reset_midcount();
    test_ctc();
    test_prescale();
    test_compb();
    test_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
